vgaconsole_term_ctrl: RTL and testbench
=======================================

# vgaconsole_term_ctrl

Terminal-style write sequencer for the VGA text console. It accepts a byte stream over a valid/ready handshake, interprets printable ASCII and a small set of control codes, and tracks a cursor. It converts the stream into single-cycle text-buffer write strobes (address, data, enable) that drive the console's 3x10 character buffer write port. It sits between a host (CPU register, UART receiver) and the console, and also performs line wrap and row/screen clearing.

## Interface
Parameters:
- NUM_ROWS, 3: text rows; buffer address = row*NUM_COLS + col.
- NUM_COLS, 10: text columns.
- BLANK_CHAR, 7'h20: glyph code written by clear operations.

Ports:
- clk  in  1  the project clock.
- rst_n  in  1  reset; one clock, reset is synchronous and active-low.
- in_data  in  8  stream byte; only bits [6:0] are interpreted, bit 7 is ignored.
- in_attr  in  1  color-select bit for a printable byte, sampled with in_data.
- in_valid  in  1  a byte is offered.
- in_ready  out  1  the block can accept a byte this cycle.
- con_addr  out  6  text-buffer cell address.
- con_data  out  8  {color_sel, 7-bit glyph}.
- con_we  out  1  one-cycle write strobe; con_addr/con_data are valid only while it is high.
- cursor_row  out  2  current cursor row, 0..NUM_ROWS-1.
- cursor_col  out  4  current cursor column, 0..NUM_COLS-1.
- busy  out  1  high in any state other than IDLE (equals ~in_ready).

## Operation
- FSM states: IDLE, WRITE, CLEAR.
  - A byte is accepted when in_valid & in_ready; in_ready = (state==IDLE).
  - In IDLE, con_we is 0.
- Byte decode on accept (b = in_data[6:0]):
  - Printable 0x20..0x7E: go to WRITE. The block latches con_addr = row*NUM_COLS+col and con_data = {in_attr, b}, then advances the cursor.
  - 0x0A LF / 0x0D CR: col ← 0. LF also sets row ← row+1, wrapping NUM_ROWS-1 → 0, then enters CLEAR for the new row. CR changes only col and stays in IDLE.
  - 0x08 BS: if col > 0, col ← col-1 and the block goes to WRITE with {0, BLANK_CHAR} at the new position. If col = 0, no action.
  - 0x0C FF: cursor ← (0,0), then CLEAR of all NUM_ROWS*NUM_COLS cells.
  - Any other code: consumed and ignored; no state change.
- Cursor advance after a printable byte:
  - col < NUM_COLS-1: col+1.
  - Otherwise: col ← 0 and row ← row+1, wrapping. After WRITE the FSM enters CLEAR for the new row (autowrap).
- WRITE: lasts exactly 1 cycle with con_we=1. It then returns to IDLE, or to CLEAR on autowrap.
- CLEAR:
  - One write per cycle, con_data = {0, BLANK_CHAR}.
  - The clear counter runs over the target range in ascending address order: row*NUM_COLS .. row*NUM_COLS+NUM_COLS-1 for a row clear, 0..NUM_ROWS*NUM_COLS-1 for FF.
  - The FSM returns to IDLE after the last address.
  - The cursor is unchanged during CLEAR.
- Address arithmetic:
  - row*NUM_COLS+col is computed in 6 bits. It never exceeds NUM_ROWS*NUM_COLS-1.
  - No address ≥ NUM_ROWS*NUM_COLS is ever emitted, so color/VGA registers are never written.

## Timing
- Reset values: state IDLE, in_ready=1, busy=0, con_we=0, con_addr=0, con_data=0, cursor (0,0), clear counter 0.
- Reset asserted mid-WRITE/CLEAR aborts the operation. con_we is 0 from the cycle after the reset edge, and no further writes are issued.
- All outputs are registered.
- Printable byte accepted at edge N: con_we high during cycle N+1 only, and the cursor shows the advanced value in cycle N+1. in_ready is low in N+1 and high again in N+2, giving a throughput of 1 char / 2 cycles.
- LF accepted at edge N: con_we high in cycles N+1..N+NUM_COLS. in_ready returns in N+NUM_COLS+1.
- Autowrap printable at edge N: char write in N+1, row clear in N+2..N+NUM_COLS+1.
- FF: NUM_ROWS*NUM_COLS consecutive write cycles.
- CR and ignored codes: in_ready stays high, so back-to-back accepts are possible.
- in_valid while busy is not accepted. The host must hold the byte; there is no loss and no duplicate.

## Test plan
- Reset, then stream "HI" with attr=1 → writes (addr 0, 0xC8) and (addr 1, 0xC9) one cycle after each accept. The cursor ends at (0,2), and in_ready toggles 1,0,1.
- 10 printables on row 0, then 'X' → 'X' is written at address 10 with the cursor at (1,1). Wait: the 10th char is written at address 9, then addresses 10..19 are cleared with 0x20 over 10 cycles, then 'X' is written at address 10.
- Cursor at (2,4), send LF → cursor goes to (0,0) and addresses 0..9 are cleared with 0x20. in_ready is low for exactly 10 cycles.
- BS at (1,3) → one write (addr 12, 0x20), cursor (1,2). BS at (0,0) → no write, in_ready stays high.
- FF at cursor (2,7) → 30 consecutive writes to addresses 0..29 with data 0x20, cursor (0,0). A CR and a 0x07 issued afterwards produce no writes.
- Assert rst_n=0 during FF clear cycle 5 → con_we is 0 from the next cycle, the cursor is (0,0), and in_ready=1 after release.

Source files
------------

// File: rtl/vgaconsole_term_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : vgaconsole_term_ctrl
//  Description : Terminal-style write sequencer for the VGA text console.
//                Accepts a byte stream, tracks a cursor, and turns printable
//                characters and control codes into single-cycle text-buffer
//                write strobes, including line wrap and row/screen clearing.
//  Revision    : 1.0 - initial release
// ============================================================================
module vgaconsole_term_ctrl #(
    parameter int         NUM_ROWS   = 3,
    parameter int         NUM_COLS   = 10,
    parameter logic [6:0] BLANK_CHAR = 7'h20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in_data,
    input  logic       in_attr,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [5:0] con_addr,
    output logic [7:0] con_data,
    output logic       con_we,
    output logic [1:0] cursor_row,
    output logic [3:0] cursor_col,
    output logic       busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_CLEAR = 2'd2
    } state_t;

    localparam logic [5:0] c_cols       = 6'(NUM_COLS);
    localparam logic [5:0] c_cells_last = 6'(NUM_ROWS * NUM_COLS - 1);
    localparam logic [1:0] c_row_last   = 2'(NUM_ROWS - 1);
    localparam logic [3:0] c_col_last   = 4'(NUM_COLS - 1);
    localparam logic [7:0] c_blank      = {1'b0, BLANK_CHAR};

    state_t     r_state, w_state;
    logic [1:0] r_row, w_row;
    logic [3:0] r_col, w_col;
    logic [5:0] r_addr, w_addr;   // doubles as the clear counter
    logic [7:0] r_data, w_data;
    logic       r_we, w_we;
    logic [5:0] r_last, w_last;   // final address of the running clear
    logic       r_wrap, w_wrap;   // pending row clear after a WRITE

    logic [6:0] w_b;
    logic       w_printable;
    logic [1:0] w_row_inc;
    logic [5:0] w_cell;
    logic [5:0] w_inc_base;
    logic [5:0] w_cur_base;
    logic       w_unused;

    assign w_b         = in_data[6:0];
    assign w_unused    = in_data[7];
    assign w_printable = (w_b >= 7'h20) && (w_b <= 7'h7E);
    assign w_row_inc   = (r_row == c_row_last) ? 2'd0 : r_row + 2'd1;
    assign w_cur_base  = {4'd0, r_row} * c_cols;
    assign w_inc_base  = {4'd0, w_row_inc} * c_cols;
    assign w_cell      = w_cur_base + {2'd0, r_col};

    // State, cursor and registered write-port outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_row   <= 2'd0;
            r_col   <= 4'd0;
            r_addr  <= 6'd0;
            r_data  <= 8'd0;
            r_we    <= 1'b0;
            r_last  <= 6'd0;
            r_wrap  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_row   <= w_row;
            r_col   <= w_col;
            r_addr  <= w_addr;
            r_data  <= w_data;
            r_we    <= w_we;
            r_last  <= w_last;
            r_wrap  <= w_wrap;
        end
    end

    // Byte decode, cursor movement and write/clear sequencing
    always_comb begin
        w_state = r_state;
        w_row   = r_row;
        w_col   = r_col;
        w_addr  = r_addr;
        w_data  = r_data;
        w_we    = 1'b0;
        w_last  = r_last;
        w_wrap  = r_wrap;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    if (w_printable) begin
                        w_state = S_WRITE;
                        w_we    = 1'b1;
                        w_addr  = w_cell;
                        w_data  = {in_attr, w_b};
                        if (r_col == c_col_last) begin
                            w_col  = 4'd0;
                            w_row  = w_row_inc;
                            w_wrap = 1'b1;
                        end else begin
                            w_col  = r_col + 4'd1;
                            w_wrap = 1'b0;
                        end
                    end else if (w_b == 7'h0A) begin
                        // LF: next row, then blank it
                        w_col   = 4'd0;
                        w_row   = w_row_inc;
                        w_state = S_CLEAR;
                        w_we    = 1'b1;
                        w_addr  = w_inc_base;
                        w_last  = w_inc_base + c_cols - 6'd1;
                        w_data  = c_blank;
                    end else if (w_b == 7'h0D) begin
                        w_col = 4'd0;
                    end else if (w_b == 7'h08) begin
                        // BS at column 0 is a no-op
                        if (r_col != 4'd0) begin
                            w_col   = r_col - 4'd1;
                            w_state = S_WRITE;
                            w_we    = 1'b1;
                            w_addr  = w_cell - 6'd1;
                            w_data  = c_blank;
                            w_wrap  = 1'b0;
                        end
                    end else if (w_b == 7'h0C) begin
                        // FF: home cursor and blank the whole screen
                        w_row   = 2'd0;
                        w_col   = 4'd0;
                        w_state = S_CLEAR;
                        w_we    = 1'b1;
                        w_addr  = 6'd0;
                        w_last  = c_cells_last;
                        w_data  = c_blank;
                    end
                end
            end
            S_WRITE: begin
                if (r_wrap) begin
                    // Autowrap: the cursor already points at the new row
                    w_state = S_CLEAR;
                    w_we    = 1'b1;
                    w_addr  = w_cur_base;
                    w_last  = w_cur_base + c_cols - 6'd1;
                    w_data  = c_blank;
                end else begin
                    w_state = S_IDLE;
                end
            end
            S_CLEAR: begin
                if (r_addr == r_last) begin
                    w_state = S_IDLE;
                end else begin
                    w_we   = 1'b1;
                    w_addr = r_addr + 6'd1;
                end
            end
            default: w_state = S_IDLE;
        endcase
    end

    assign in_ready   = (r_state == S_IDLE);
    assign busy       = (r_state != S_IDLE);
    assign con_addr   = r_addr;
    assign con_data   = r_data;
    assign con_we     = r_we;
    assign cursor_row = r_row;
    assign cursor_col = r_col;

endmodule
`default_nettype wire

// File: tb/tb_vgaconsole_term_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vgaconsole_term_ctrl
//  Description : Scoreboard bench for vgaconsole_term_ctrl. A reference model
//                of the terminal predicts every buffer write and the cursor;
//                a negedge monitor pops and compares each observed write.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vgaconsole_term_ctrl;

    localparam int NR = 3;
    localparam int NC = 10;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] in_data;
    logic       in_attr;
    logic       in_valid;
    logic       in_ready;
    logic [5:0] con_addr;
    logic [7:0] con_data;
    logic       con_we;
    logic [1:0] cursor_row;
    logic [3:0] cursor_col;
    logic       busy;

    vgaconsole_term_ctrl #(
        .NUM_ROWS   (NR),
        .NUM_COLS   (NC),
        .BLANK_CHAR (7'h20)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_attr    (in_attr),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .con_addr   (con_addr),
        .con_data   (con_data),
        .con_we     (con_we),
        .cursor_row (cursor_row),
        .cursor_col (cursor_col),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [13:0] exp_q[$];        // {addr, data} of each expected write
    logic [13:0] e;
    bit          mon_en = 1'b0;
    int          m_row = 0;
    int          m_col = 0;
    logic [7:0]  tx_b[$];
    logic        tx_a[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    function automatic void push_w(input int addr, input int dat);
        exp_q.push_back({6'(addr), 8'(dat)});
    endfunction

    function automatic void push_clear(input int first, input int count);
        for (int a = first; a < first + count; a++) push_w(a, 8'h20);
    endfunction

    // Terminal model: applies one accepted byte, queues its writes,
    // and returns how many cycles the block should stay busy.
    function automatic int model_accept(input logic [7:0] d, input logic a);
        int b;
        int cyc;
        b   = int'(d[6:0]);
        cyc = 0;
        if (b >= 32 && b <= 126) begin
            push_w(m_row * NC + m_col, (a ? 128 : 0) + b);
            cyc = 1;
            m_col++;
            if (m_col == NC) begin
                m_col = 0;
                m_row = (m_row + 1) % NR;
                push_clear(m_row * NC, NC);
                cyc += NC;
            end
        end else if (b == 10) begin
            m_col = 0;
            m_row = (m_row + 1) % NR;
            push_clear(m_row * NC, NC);
            cyc = NC;
        end else if (b == 13) begin
            m_col = 0;
        end else if (b == 8) begin
            if (m_col > 0) begin
                m_col--;
                push_w(m_row * NC + m_col, 8'h20);
                cyc = 1;
            end
        end else if (b == 12) begin
            m_row = 0;
            m_col = 0;
            push_clear(0, NR * NC);
            cyc = NR * NC;
        end
        return cyc;
    endfunction

    // Monitor: every write the DUT presents must match the scoreboard head
    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            chk("busy_vs_ready", int'(busy), int'(!in_ready));
            if (con_we) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: addr %0d data 0x%0h, expected no write", con_addr, con_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_addr", int'(con_addr), int'(e[13:8]));
                    chk("wr_data", int'(con_data), int'(e[7:0]));
                end
            end
        end
    end

    // Sends the queued bytes; with hold=1 the next byte is offered while busy
    task automatic send_seq(input bit hold);
        int n;
        int k;
        int cyc;
        int exp_cyc;
        n = tx_b.size();
        @(negedge clk);
        if (n > 0) begin
            in_data  = tx_b[0];
            in_attr  = tx_a[0];
            in_valid = 1'b1;
        end
        for (int i = 0; i < n; i++) begin
            k = 0;
            while (!in_ready && k < 100) begin
                @(negedge clk);
                k++;
            end
            if (k >= 100) begin
                checks++;
                errors++;
                $display("FAIL ready_timeout: in_ready low for %0d cycles, expected high", k);
                in_valid = 1'b0;
                break;
            end
            @(posedge clk);
            exp_cyc = model_accept(in_data, in_attr);
            #1;
            if (hold && i + 1 < n) begin
                in_data = tx_b[i+1];
                in_attr = tx_a[i+1];
            end else begin
                in_valid = 1'b0;
            end
            cyc = 0;
            @(negedge clk);
            while (!in_ready && cyc < 100) begin
                cyc++;
                @(negedge clk);
            end
            chk("busy_cycles", cyc, exp_cyc);
            chk("cursor_row", int'(cursor_row), m_row);
            chk("cursor_col", int'(cursor_col), m_col);
            if (!hold && i + 1 < n) begin
                in_data  = tx_b[i+1];
                in_attr  = tx_a[i+1];
                in_valid = 1'b1;
            end
        end
        tx_b.delete();
        tx_a.delete();
    endtask

    task automatic q_str(input string s, input logic a);
        for (int i = 0; i < s.len(); i++) begin
            tx_b.push_back(8'(s[i]));
            tx_a.push_back(a);
        end
    endtask

    task automatic q_byte(input logic [7:0] b);
        tx_b.push_back(b);
        tx_a.push_back(1'b0);
    endtask

    initial begin
        logic [7:0] ctl[8];
        logic [7:0] rb;
        int         r;
        ctl = '{8'h0A, 8'h0D, 8'h08, 8'h0C, 8'h07, 8'h00, 8'h1B, 8'h7F};

        rst_n    = 1'b0;
        in_data  = 8'd0;
        in_attr  = 1'b0;
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_con_we", int'(con_we), 0);
        chk("rst_con_addr", int'(con_addr), 0);
        chk("rst_con_data", int'(con_data), 0);
        chk("rst_cursor_row", int'(cursor_row), 0);
        chk("rst_cursor_col", int'(cursor_col), 0);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // "HI" with attr set, then fill row 0 and wrap with 'X'
        q_str("HI", 1'b1);
        send_seq(1'b0);
        q_str("abcdefgh", 1'b0);
        q_str("X", 1'b0);
        send_seq(1'b0);

        // Cursor to (2,4), then LF wraps to row 0
        q_byte(8'h0A);
        q_str("abcd", 1'b1);
        q_byte(8'h0A);
        send_seq(1'b0);

        // BS at (1,3), then BS at (0,0)
        q_byte(8'h0A);
        q_str("xyz", 1'b0);
        q_byte(8'h08);
        q_byte(8'h0A);
        q_byte(8'h0A);
        q_byte(8'h08);
        send_seq(1'b0);

        // FF from (2,7), then CR and BEL back to back
        q_byte(8'h0A);
        q_byte(8'h0A);
        q_str("1234567", 1'b0);
        q_byte(8'h0C);
        q_byte(8'h0D);
        q_byte(8'h87);
        send_seq(1'b1);

        // Randomized batches, alternating idle-gap and held-valid hosts
        for (int batch = 0; batch < 30; batch++) begin
            for (int j = 0; j < 10; j++) begin
                r = int'($urandom_range(0, 9));
                if (r < 6) rb = 8'($urandom_range(32, 126));
                else       rb = ctl[$urandom_range(0, 7)];
                rb[7] = 1'($urandom_range(0, 1));
                tx_b.push_back(rb);
                tx_a.push_back(1'($urandom_range(0, 1)));
            end
            send_seq(1'($urandom_range(0, 1)));
        end

        // Reset during the fifth write of a screen clear
        @(negedge clk);
        in_data  = 8'h0C;
        in_valid = 1'b1;
        @(posedge clk);
        void'(model_accept(in_data, in_attr));
        #1;
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        exp_q.delete();
        m_row = 0;
        m_col = 0;
        @(negedge clk);
        chk("abort_con_we", int'(con_we), 0);
        chk("abort_in_ready", int'(in_ready), 1);
        chk("abort_cursor_row", int'(cursor_row), 0);
        chk("abort_cursor_col", int'(cursor_col), 0);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_con_we", int'(con_we), 0);

        q_str("OK", 1'b1);
        send_seq(1'b0);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
